// File: rtl/usb_pe_tx_packetizer.sv
// USB protocol-engine transmit packetizer: emits handshake and DATA0/DATA1 packets to the SIE,
// popping payload from an IN endpoint FIFO. Define USB_PE_TX_MAXPKT_EN to cap payload at MAX_PKT_BYTES.
module usb_pe_tx_packetizer #(
  parameter int EP_DATA_WID   = 8,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic                   clk48,
  input  logic                   rst_n,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic [1:0]             cmdType,
  input  logic                   cmdDataToggle,
  output logic                   txReqSendPacket,
  output logic                   txDataValid,
  output logic                   txIsLastByte,
  output logic [7:0]             txData,
  input  logic                   txAcceptNewData,
  output logic                   READ_EN,
  input  logic [EP_DATA_WID-1:0] rdata,
  input  logic                   readDataAvailable,
  output logic                   popTransDone,
  output logic                   popTransSuccess,
  input  logic                   transCommit,
  input  logic                   transRollback,
  output logic                   isSendingPhase
);

  if (EP_DATA_WID != 8 || MAX_PKT_BYTES < 1) begin : gBadParam
    $error("usb_pe_tx_packetizer: EP_DATA_WID must be 8 and MAX_PKT_BYTES at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND_PID,
    SEND_DATA,
    WAIT_COMMIT
  } txState_t;

  localparam logic [1:0] CMD_ACK   = 2'd0;
  localparam logic [1:0] CMD_NAK   = 2'd1;
  localparam logic [1:0] CMD_STALL = 2'd2;

  txState_t               state;
  txState_t               stateNext;
  logic [7:0]             pidReg;
  logic                   isData;
  logic [EP_DATA_WID-1:0] holdReg;
  logic                   holdValid;
  logic [3:0]             pidNibble;
  logic                   cmdIsData;
  logic                   cmdAccept;
  logic                   byteAccept;
  logic                   canPop;

  assign cmdIsData  = (cmdType == 2'd3);
  assign cmdAccept  = cmdValid && cmdReady;
  assign byteAccept = txDataValid && txAcceptNewData;

`ifdef USB_PE_TX_MAXPKT_EN
  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_BYTES);

  logic [CNT_W-1:0] byteCnt;

  // Bytes already popped for this packet, including the one held for transmission.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt <= '0;
    end else if (cmdAccept) begin
      byteCnt <= READ_EN ? CNT_W'(1) : '0;
    end else if (READ_EN) begin
      byteCnt <= byteCnt + CNT_W'(1);
    end
  end

  assign canPop = readDataAvailable && (byteCnt < CNT_MAX);
`else
  assign canPop = readDataAvailable;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pidNibble = 4'b0010;
    case (cmdType)
      CMD_ACK:   pidNibble = 4'b0010;
      CMD_NAK:   pidNibble = 4'b1010;
      CMD_STALL: pidNibble = 4'b1110;
      default:   pidNibble = cmdDataToggle ? 4'b1011 : 4'b0011;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cmdAccept) stateNext = SEND_PID;
      end
      SEND_PID: begin
        if (byteAccept) begin
          if (!isData)        stateNext = IDLE;
          else if (holdValid) stateNext = SEND_DATA;
          else                stateNext = WAIT_COMMIT;
        end
      end
      SEND_DATA: begin
        if (byteAccept && !canPop) stateNext = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (transRollback || transCommit) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The byte on txData is always pre-fetched: one pop ahead of the SIE handshake.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      pidReg    <= '0;
      isData    <= 1'b0;
      // NOTE: holdReg is a single byte, so clearing it on reset is cheap; bulk storage would stay unreset.
      holdReg   <= '0;
      holdValid <= 1'b0;
    end else begin
      if (cmdAccept) begin
        pidReg    <= {~pidNibble, pidNibble};
        isData    <= cmdIsData;
        holdValid <= READ_EN;
      end
      if (READ_EN) holdReg <= rdata;
    end
  end

  always_comb begin
    cmdReady        = 1'b0;
    txReqSendPacket = 1'b0;
    txDataValid     = 1'b0;
    txIsLastByte    = 1'b0;
    txData          = '0;
    READ_EN         = 1'b0;
    popTransDone    = 1'b0;
    popTransSuccess = 1'b0;
    isSendingPhase  = 1'b1;
    case (state)
      IDLE: begin
        cmdReady       = 1'b1;
        isSendingPhase = 1'b0;
        READ_EN        = cmdValid && cmdIsData && readDataAvailable;
      end
      SEND_PID: begin
        txReqSendPacket = 1'b1;
        txDataValid     = 1'b1;
        txData          = pidReg;
        txIsLastByte    = !isData || !holdValid;
      end
      SEND_DATA: begin
        txReqSendPacket = 1'b1;
        txDataValid     = 1'b1;
        txData          = holdReg;
        txIsLastByte    = !canPop;
        READ_EN         = txAcceptNewData && canPop;
      end
      WAIT_COMMIT: begin
        // Rollback dominates a simultaneous commit.
        popTransDone    = transRollback || transCommit;
        popTransSuccess = transCommit && !transRollback;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_pe_tx_packetizer.sv
// Scoreboard bench for usb_pe_tx_packetizer: packet-level reference model, FIFO model with
// commit/rewind, randomized SIE back-pressure and verdicts. Honours USB_PE_TX_MAXPKT_EN.
module tb_usb_pe_tx_packetizer;

  localparam int MAXB = 4;
`ifdef USB_PE_TX_MAXPKT_EN
  localparam int LIMIT = MAXB;
`else
  localparam int LIMIT = 1 << 30;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
  } expByte_t;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdType;
  logic       cmdDataToggle;
  logic       txReqSendPacket;
  logic       txDataValid;
  logic       txIsLastByte;
  logic [7:0] txData;
  logic       txAcceptNewData;
  logic       READ_EN;
  logic [7:0] rdata;
  logic       readDataAvailable;
  logic       popTransDone;
  logic       popTransSuccess;
  logic       transCommit;
  logic       transRollback;
  logic       isSendingPhase;

  int vectors = 0;
  int miscompares = 0;

  expByte_t   expQ[$];
  logic       verdictQ[$];
  logic [7:0] fifoQ[$];
  int         rdPtr = 0;
  int         popCnt = 0;
  bit         monEn = 1'b0;

  always #10 clk48 = ~clk48;

  usb_pe_tx_packetizer #(
    .EP_DATA_WID  (8),
    .MAX_PKT_BYTES(MAXB)
  ) dut (
    .clk48            (clk48),
    .rst_n            (rst_n),
    .cmdValid         (cmdValid),
    .cmdReady         (cmdReady),
    .cmdType          (cmdType),
    .cmdDataToggle    (cmdDataToggle),
    .txReqSendPacket  (txReqSendPacket),
    .txDataValid      (txDataValid),
    .txIsLastByte     (txIsLastByte),
    .txData           (txData),
    .txAcceptNewData  (txAcceptNewData),
    .READ_EN          (READ_EN),
    .rdata            (rdata),
    .readDataAvailable(readDataAvailable),
    .popTransDone     (popTransDone),
    .popTransSuccess  (popTransSuccess),
    .transCommit      (transCommit),
    .transRollback    (transRollback),
    .isSendingPhase   (isSendingPhase)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pidOf(input logic [1:0] t, input logic tog);
    case (t)
      2'd0:    return 8'hD2;
      2'd1:    return 8'h5A;
      2'd2:    return 8'h1E;
      default: return tog ? 8'h4B : 8'hC3;
    endcase
  endfunction

  task automatic pushExp(input logic [7:0] d, input logic l);
    expByte_t e;
    e.data = d;
    e.last = l;
    expQ.push_back(e);
  endtask

  task automatic refreshFifo();
    readDataAvailable = (rdPtr < fifoQ.size());
    rdata = readDataAvailable ? fifoQ[rdPtr] : 8'h00;
  endtask

  task automatic loadFifo(input int n);
    for (int i = 0; i < n; i++) fifoQ.push_back(8'($urandom));
    refreshFifo();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkBit({tag, " cmdReady"}, cmdReady, 1'b1);
    checkBit({tag, " txReqSendPacket"}, txReqSendPacket, 1'b0);
    checkBit({tag, " txDataValid"}, txDataValid, 1'b0);
    checkBit({tag, " txIsLastByte"}, txIsLastByte, 1'b0);
    check({tag, " txData"}, int'(txData), 0);
    checkBit({tag, " READ_EN"}, READ_EN, 1'b0);
    checkBit({tag, " popTransDone"}, popTransDone, 1'b0);
    checkBit({tag, " popTransSuccess"}, popTransSuccess, 1'b0);
    checkBit({tag, " isSendingPhase"}, isSendingPhase, 1'b0);
  endtask

  // Endpoint FIFO model: pops advance a read pointer; commit drops popped bytes, rollback rewinds.
  initial begin : fifoEnv
    logic doPop, done, succ, rdaS;
    forever begin
      @(negedge clk48);
      doPop = READ_EN && rst_n;
      done  = popTransDone && rst_n;
      succ  = popTransSuccess;
      rdaS  = readDataAvailable;
      @(posedge clk48);
      #1;
      if (doPop) begin
        popCnt++;
        checkBit("READ_EN only with readDataAvailable", rdaS, 1'b1);
        if (rdPtr < fifoQ.size()) rdPtr++;
      end
      if (done) begin
        if (succ) for (int i = 0; i < rdPtr; i++) fifoQ.delete(0);
        rdPtr = 0;
      end
      refreshFifo();
    end
  end

  // Monitor: every presented byte must match the scoreboard head; pop only on handshake.
  always @(negedge clk48) begin
    if (rst_n && monEn) begin
      if (txDataValid) begin
        if (expQ.size() == 0) begin
          checkBit("txDataValid with no byte expected", txDataValid, 1'b0);
        end else begin
          check("txData", int'(txData), int'(expQ[0].data));
          checkBit("txIsLastByte", txIsLastByte, expQ[0].last);
          checkBit("txReqSendPacket", txReqSendPacket, 1'b1);
          if (txAcceptNewData) expQ.delete(0);
        end
      end
      if (popTransDone) begin
        if (verdictQ.size() == 0) begin
          checkBit("popTransDone with no verdict expected", popTransDone, 1'b0);
        end else begin
          checkBit("popTransSuccess", popTransSuccess, verdictQ[0]);
          verdictQ.delete(0);
        end
      end
    end
  end

  // verdict: 0=commit, 1=rollback, 2=both; stallMode: 0=always ready, 1=toggle, 2=random.
  task automatic runPkt(input logic [1:0] t, input logic tog, input int stallMode,
                        input int verdict, input int waitCyc);
    int len;
    int sizeBefore;
    int budget;
    int expSize;
    len = 0;
    sizeBefore = fifoQ.size();
    if (t == 2'd3) begin
      len = fifoQ.size() - rdPtr;
      if (len > LIMIT) len = LIMIT;
      pushExp(pidOf(t, tog), len == 0);
      for (int i = 0; i < len; i++) pushExp(fifoQ[rdPtr + i], i == len - 1);
      verdictQ.push_back(verdict == 0);
    end else begin
      pushExp(pidOf(t, tog), 1'b1);
    end
    popCnt = 0;

    cmdValid = 1'b1;
    cmdType = t;
    cmdDataToggle = tog;
    @(negedge clk48);
    checkBit("cmdReady in IDLE", cmdReady, 1'b1);
    @(posedge clk48);
    #1;
    cmdValid = 1'b0;
    cmdType = 2'($urandom);
    cmdDataToggle = 1'($urandom);
    checkBit("isSendingPhase after accept", isSendingPhase, 1'b1);

    budget = 0;
    while (expQ.size() > 0 && budget < 300) begin
      case (stallMode)
        0:       txAcceptNewData = 1'b1;
        1:       txAcceptNewData = !txAcceptNewData;
        default: txAcceptNewData = 1'($urandom_range(0, 1));
      endcase
      transRollback = (t == 2'd3) && ($urandom_range(0, 5) == 0);
      transCommit   = (t == 2'd3) && ($urandom_range(0, 5) == 0);
      @(posedge clk48);
      #1;
      budget++;
    end
    transRollback = 1'b0;
    transCommit = 1'b0;
    txAcceptNewData = 1'($urandom_range(0, 1));
    if (expQ.size() > 0) begin
      check("bytes left at tx timeout", expQ.size(), 0);
      expQ.delete();
    end
    if (t != 2'd3 && stallMode == 0) checkBit("cmdReady 2 cycles after accept", cmdReady, 1'b1);

    if (t == 2'd3) begin
      repeat (waitCyc) begin
        checkBit("txDataValid low in WAIT_COMMIT", txDataValid, 1'b0);
        checkBit("isSendingPhase in WAIT_COMMIT", isSendingPhase, 1'b1);
        @(posedge clk48);
        #1;
      end
      transCommit = (verdict != 1);
      transRollback = (verdict != 0);
      budget = 0;
      while (verdictQ.size() > 0 && budget < 20) begin
        @(posedge clk48);
        #1;
        budget++;
      end
      transCommit = 1'b0;
      transRollback = 1'b0;
      if (verdictQ.size() > 0) begin
        check("verdicts left at popTransDone timeout", verdictQ.size(), 0);
        verdictQ.delete();
      end
    end

    #1;
    check("READ_EN pulses per packet", popCnt, len);
    expSize = (t == 2'd3 && verdict == 0) ? sizeBefore - len : sizeBefore;
    check("FIFO depth after packet", fifoQ.size(), expSize);
    checkBit("cmdReady after packet", cmdReady, 1'b1);
    @(posedge clk48);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int remain;
    rst_n = 1'b0;
    cmdValid = 1'b0;
    cmdType = 2'd0;
    cmdDataToggle = 1'b0;
    txAcceptNewData = 1'b0;
    transCommit = 1'b0;
    transRollback = 1'b0;
    refreshFifo();
    #15;
    checkIdleOutputs("reset");
    #20;
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    monEn = 1'b1;

    runPkt(2'd0, 1'b0, 0, 0, 0);

    fifoQ.push_back(8'h11);
    fifoQ.push_back(8'h22);
    fifoQ.push_back(8'h33);
    refreshFifo();
    runPkt(2'd3, 1'b1, 0, 0, 1);

    runPkt(2'd3, 1'b0, 0, 1, 0);

    loadFifo(2);
    runPkt(2'd3, 1'b0, 1, 0, 0);

    loadFifo(1);
    runPkt(2'd3, 1'b1, 2, 2, 2);
    runPkt(2'd3, 1'b0, 0, 0, 0);

    runPkt(2'd1, 1'b0, 2, 0, 0);
    runPkt(2'd2, 1'b1, 1, 0, 0);

    loadFifo(6);
    runPkt(2'd3, 1'b0, 0, 0, 0);
    remain = (LIMIT < 6) ? 6 - LIMIT : 0;
    checkBit("readDataAvailable after capped packet", readDataAvailable, remain > 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] t;
      if (fifoQ.size() < 8) loadFifo(int'($urandom_range(0, 4)));
      t = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      runPkt(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while holding a payload byte in SEND_DATA.
    monEn = 1'b0;
    if (fifoQ.size() < 2) loadFifo(2);
    cmdValid = 1'b1;
    cmdType = 2'd3;
    cmdDataToggle = 1'b1;
    txAcceptNewData = 1'b1;
    @(posedge clk48);
    #1;
    cmdValid = 1'b0;
    @(posedge clk48);
    #1;
    txAcceptNewData = 1'b0;
    check("txData held in SEND_DATA", int'(txData), int'(fifoQ[0]));
    checkBit("txIsLastByte before reset", txIsLastByte, (fifoQ.size() < 2) || (LIMIT < 2));
    #3;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("mid-packet reset");
    rdPtr = 0;
    refreshFifo();
    @(posedge clk48);
    @(posedge clk48);
    #3;
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    expQ.delete();
    verdictQ.delete();
    monEn = 1'b1;

    runPkt(2'd0, 1'b0, 0, 0, 0);
    runPkt(2'd3, 1'b0, 2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
